simmem_read_only: RTL

//  Read-path counterpart of the simulated memory controller's write path. Forwards read-address

---
 rtl/simmem_pkg.sv | 40 ++++
 rtl/simmem_read_only_if.sv | 32 +++
 rtl/simmem_age_matrix.sv | 67 ++++++
 rtl/simmem_read_only.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// rtl/simmem_pkg.sv - shared types and slot-state decode for the simulated memory read path
package simmem_pkg;

    localparam int IdWidth   = 4;
    localparam int AddrWidth = 32;
    localparam int DataWidth = 64;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
    } read_addr_req_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic                 last;
    } read_data_t;

    typedef enum logic [2:0] {
        SLOT_FREE,
        SLOT_PENDING,
        SLOT_TIMED,
        SLOT_FILLED,
        SLOT_READY
    } slot_state_e;

    // A slot's state is fully implied by its busy flag, data flag and whether its delay expired.
    function automatic slot_state_e decode_slot(input logic busy, input logic has_data,
                                                input logic cnt_zero);
        if (!busy) begin
            return SLOT_FREE;
        end
        if (has_data) begin
            return cnt_zero ? SLOT_READY : SLOT_FILLED;
        end
        return cnt_zero ? SLOT_TIMED : SLOT_PENDING;
    endfunction

endpackage

// File: rtl/simmem_read_only_if.sv
// rtl/simmem_read_only_if.sv - address and read-data handshake bundle of the read path
interface simmem_read_only_if;
    import simmem_pkg::*;

    logic           raddr_in_valid_i;
    logic           raddr_in_ready_o;
    read_addr_req_t raddr_in_data_i;
    logic           raddr_out_valid_o;
    logic           raddr_out_ready_i;
    read_addr_req_t raddr_out_data_o;
    logic           rdata_in_valid_i;
    logic           rdata_in_ready_o;
    read_data_t     rdata_in_data_i;
    logic           rdata_out_valid_o;
    logic           rdata_out_ready_i;
    read_data_t     rdata_out_data_o;

    modport slave (
        input  raddr_in_valid_i, raddr_in_data_i, raddr_out_ready_i,
        input  rdata_in_valid_i, rdata_in_data_i, rdata_out_ready_i,
        output raddr_in_ready_o, raddr_out_valid_o, raddr_out_data_o,
        output rdata_in_ready_o, rdata_out_valid_o, rdata_out_data_o
    );

    modport master (
        output raddr_in_valid_i, raddr_in_data_i, raddr_out_ready_i,
        output rdata_in_valid_i, rdata_in_data_i, rdata_out_ready_i,
        input  raddr_in_ready_o, raddr_out_valid_o, raddr_out_data_o,
        input  rdata_in_ready_o, rdata_out_valid_o, rdata_out_data_o
    );

endinterface

// File: rtl/simmem_age_matrix.sv
// rtl/simmem_age_matrix.sv - relative-age tracker picking the oldest slot of two request sets
module simmem_age_matrix #(
    parameter int NumSlots = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NumSlots-1:0] alloc_oh,
    input  logic [NumSlots-1:0] free_oh,
    input  logic [NumSlots-1:0] req_a,
    input  logic [NumSlots-1:0] req_b,
    output logic [NumSlots-1:0] oldest_a,
    output logic [NumSlots-1:0] oldest_b
);

    // older[i][j] == 1 means slot i was allocated before slot j
    logic [NumSlots-1:0][NumSlots-1:0] older;
    logic [NumSlots-1:0][NumSlots-1:0] older_next;

    // A request wins when it is older than every other requesting slot.
    function automatic logic [NumSlots-1:0] pick_oldest(
        input logic [NumSlots-1:0]               req,
        input logic [NumSlots-1:0][NumSlots-1:0] m
    );
        logic [NumSlots-1:0] sel;
        sel = req;
        for (int i = 0; i < NumSlots; i++) begin
            for (int j = 0; j < NumSlots; j++) begin
                if (i != j && req[j] && !m[i][j]) begin
                    sel[i] = 1'b0;
                end
            end
        end
        return sel;
    endfunction

    // New slot becomes youngest; freed slots drop out of every relation.
    always_comb begin
        older_next = older;
        for (int i = 0; i < NumSlots; i++) begin
            for (int j = 0; j < NumSlots; j++) begin
                if (i == j) begin
                    older_next[i][j] = 1'b0;
                end else if (alloc_oh[j]) begin
                    older_next[i][j] = 1'b1;
                end else if (alloc_oh[i] || free_oh[i] || free_oh[j]) begin
                    older_next[i][j] = 1'b0;
                end
            end
        end
    end

    // Age matrix register.
    always_ff @(posedge clk) begin
        if (rst) begin
            older <= '0;
        end else begin
            older <= older_next;
        end
    end

    // Oldest-first selection for both request vectors.
    always_comb begin
        oldest_a = pick_oldest(req_a, older);
        oldest_b = pick_oldest(req_b, older);
    end

endmodule

// File: rtl/simmem_read_only.sv
// rtl/simmem_read_only.sv - read path that delays returned data by a minimum read latency
module simmem_read_only
    import simmem_pkg::*;
#(
    parameter int NumSlots    = 8,
    parameter int ReadLatency = 10,
    parameter int DelayWidth  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    simmem_read_only_if.slave bus
);

    localparam logic [DelayWidth-1:0] LoadCnt = DelayWidth'(ReadLatency - 1);
    localparam int StallLimit = 2 * ReadLatency;
    localparam int StallW     = $clog2(StallLimit + 2);

    logic [NumSlots-1:0]                 slot_busy;
    logic [NumSlots-1:0]                 slot_has_data;
    logic [NumSlots-1:0][DelayWidth-1:0] slot_cnt;
    logic [NumSlots-1:0][IdWidth-1:0]    slot_id;
    read_data_t                          slot_data [NumSlots];
    slot_state_e                         slot_state [NumSlots];

    logic [NumSlots-1:0] free_vec;
    logic [NumSlots-1:0] ready_vec;
    logic [NumSlots-1:0] data_cand;
    logic [NumSlots-1:0] data_target;
    logic [NumSlots-1:0] oldest_ready;
    logic [NumSlots-1:0] alloc_oh;
    logic [NumSlots-1:0] fill_oh;
    logic [NumSlots-1:0] release_oh;
    logic [NumSlots-1:0] rel_sel;
    logic [NumSlots-1:0] rel_lock_oh;
    logic                rel_lock;
    logic                free_any;
    logic                addr_hs;
    logic                rdata_in_ready;
    logic                rdata_out_valid;
    read_data_t          rdata_sel;
    logic [StallW-1:0]   stall_cnt;

    // Decode per-slot state and build the candidate vectors for the age matrix.
    always_comb begin
        for (int i = 0; i < NumSlots; i++) begin
            slot_state[i] = decode_slot(slot_busy[i], slot_has_data[i], slot_cnt[i] == '0);
            free_vec[i]   = (slot_state[i] == SLOT_FREE);
            ready_vec[i]  = (slot_state[i] == SLOT_READY);
            data_cand[i]  = ((slot_state[i] == SLOT_PENDING) || (slot_state[i] == SLOT_TIMED))
                            && (slot_id[i] == bus.rdata_in_data_i.id);
        end
    end

    assign free_any = |free_vec;
    assign addr_hs  = bus.raddr_in_valid_i & bus.raddr_out_ready_i & free_any;

    assign bus.raddr_out_valid_o = bus.raddr_in_valid_i & free_any;
    assign bus.raddr_in_ready_o  = bus.raddr_out_ready_i & free_any;
    assign bus.raddr_out_data_o  = bus.raddr_in_data_i;

    // Allocate the lowest-index free slot on an address handshake.
    always_comb begin
        logic found;
        alloc_oh = '0;
        found    = 1'b0;
        for (int i = 0; i < NumSlots; i++) begin
            if (!found && free_vec[i]) begin
                alloc_oh[i] = addr_hs;
                found       = 1'b1;
            end
        end
    end

    simmem_age_matrix #(
        .NumSlots (NumSlots)
    ) u_age_matrix (
        .clk      (clk_i),
        .rst      (rst_i),
        .alloc_oh (alloc_oh),
        .free_oh  (release_oh),
        .req_a    (data_cand),
        .req_b    (ready_vec),
        .oldest_a (data_target),
        .oldest_b (oldest_ready)
    );

    assign rdata_in_ready       = |data_cand;
    assign bus.rdata_in_ready_o = rdata_in_ready;
    assign fill_oh              = data_target & {NumSlots{bus.rdata_in_valid_i & rdata_in_ready}};

    // A presented-but-unaccepted slot stays selected so the payload cannot change under the requester.
    assign rel_sel               = rel_lock ? rel_lock_oh : oldest_ready;
    assign rdata_out_valid       = |ready_vec;
    assign bus.rdata_out_valid_o = rdata_out_valid;
    assign release_oh            = rel_sel & {NumSlots{rdata_out_valid & bus.rdata_out_ready_i}};

    // Payload mux for the selected release slot.
    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (rel_sel[i]) begin
                rdata_sel = slot_data[i];
            end
        end
    end

    assign bus.rdata_out_data_o = rdata_sel;

    // Slot bookkeeping: allocation, fill, release and delay countdown.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_busy     <= '0;
            slot_has_data <= '0;
            slot_cnt      <= '0;
            slot_id       <= '0;
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                if (alloc_oh[i]) begin
                    slot_busy[i]     <= 1'b1;
                    slot_has_data[i] <= 1'b0;
                    slot_cnt[i]      <= LoadCnt;
                    slot_id[i]       <= bus.raddr_in_data_i.id;
                end else begin
                    if (release_oh[i]) begin
                        slot_busy[i]     <= 1'b0;
                        slot_has_data[i] <= 1'b0;
                    end
                    if (fill_oh[i]) begin
                        slot_has_data[i] <= 1'b1;
                    end
                    if (slot_cnt[i] != '0) begin
                        slot_cnt[i] <= slot_cnt[i] - DelayWidth'(1);
                    end
                end
            end
        end
    end

    // Read-data storage; validity is carried by the slot flags, so no reset is needed.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumSlots; i++) begin
            if (fill_oh[i]) begin
                slot_data[i] <= bus.rdata_in_data_i;
            end
        end
    end

    // Capture the selection while the requester is back-pressuring.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rel_lock    <= 1'b0;
            rel_lock_oh <= '0;
        end else if (rdata_out_valid && !bus.rdata_out_ready_i) begin
            rel_lock    <= 1'b1;
            rel_lock_oh <= rel_sel;
        end else begin
            rel_lock    <= 1'b0;
        end
    end

    // Count cycles a read-data beat waits with no matching slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (bus.rdata_in_valid_i && !rdata_in_ready) begin
            if (int'(stall_cnt) <= StallLimit) begin
                stall_cnt <= stall_cnt + StallW'(1);
            end
        end else begin
            stall_cnt <= '0;
        end
    end

    // Flag read data that never finds a matching outstanding request.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (int'(stall_cnt) <= StallLimit);
        end
    end

endmodule
